level_meter_mc: RTL and testbench
=================================

Name: level_meter_mc

Overview:
- Multi-channel successor to the single-channel LED level meter; one instance per audio path, between the ADC/codec sample bus and the board LEDs and 7-segment display.
- Per channel: rectifies offset-binary samples, runs peak-hold with linear decay and sticky clip detection.
- For one selected channel: drives a bar/dot LED meter plus a hex digit of the bar level.
- Fully synchronous to CLK; SAMPLE_TR is a clock-enable strobe, not a clock.

Parameters:
- CHANNELS, 2, number of input channels (1..8).
- DATA_W, 12, sample width, offset binary; MID = 2^(DATA_W-1).
- LED_N, 10, number of meter LEDs (1..15).
- HOLD_SAMPLES, 4800, samples a new peak is held before decay starts (>=1).
- DECAY_STEP, 16, magnitude subtracted from the peak per sample once hold expires.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- SAMPLE_TR  in  1  one-CLK-wide strobe; VALUE is valid in that cycle.
- VALUE  in  CHANNELS*DATA_W  packed samples; channel c = VALUE[c*DATA_W +: DATA_W].
- CH_SEL  in  3  channel shown on LED/HEXR.
- MODE  in  1  0 = bar, 1 = dot.
- CLIP_CLR  in  1  clears all clip flags.
- LED  out  LED_N  meter LEDs, active high.
- HEXR  out  7  segments {g,f,e,d,c,b,a}, active high.
- CLIP  out  CHANNELS  sticky full-scale flags.

Behaviour:
- Reset: synchronous, active high. On any CLK edge with RESET=1, all of the following clear to 0: magnitudes, peaks, hold counters, CLIP, LED. HEXR resets to 7'b0111111 ("0"). A SAMPLE_TR asserted while RESET=1 is discarded, and so is any sample already in the pipeline.
- Rectify (stage 1, edge after SAMPLE_TR). Per channel, mag is DATA_W-1 bits:
  - VALUE >= MID: mag = VALUE - MID.
  - VALUE == 0: mag = MID - 1 (saturate).
  - Otherwise: mag = MID - VALUE.
- Peak update (stage 2, next edge, per channel, for each valid stage-1 sample):
  - mag >= peak: peak = mag, hold = HOLD_SAMPLES.
  - Else if hold != 0: hold decrements by 1.
  - Else: peak = peak - DECAY_STEP if peak > DECAY_STEP, otherwise 0. No underflow.
  - Peak only changes on valid samples; idle cycles leave it unchanged.
- Clip: a valid stage-1 sample with mag == MID-1 sets CLIP[c]. CLIP_CLR clears all flags. If set and clear occur in the same cycle, set wins.
- Display (stage 3, next edge):
  - Channel selection: ch = CH_SEL; if CH_SEL >= CHANNELS, ch = 0.
  - Level: L = (peak[ch] * (LED_N+1)) >> (DATA_W-1), giving a range of 0..LED_N.
  - Bar mode: LED[i] = 1 for i < L.
  - Dot mode: only LED[L-1] = 1, and only when L > 0.
  - If CLIP[ch] = 1, LED[LED_N-1] is forced to 1 in either mode.
  - HEXR = hex glyph of L:
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
    - 8=1111111, 9=1100111, A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001
  - The display registers update every CLK, so a change on CH_SEL or MODE appears one cycle later.
- Latency and throughput:
  - A sample strobed at edge t affects peak at t+2 and LED/HEXR at t+3.
  - Back-to-back strobes are accepted every cycle with no loss.

Test Plan:
- Reset: apply RESET for 2 cycles with SAMPLE_TR=1 and VALUE=0xFFF -> LED=0, HEXR=0111111, CLIP=0 through 3 cycles after release.
- Rectify and level, ch0: strobe VALUE 0xC00 -> peak 0x400, LED=0x01F, HEXR=1101101 three cycles after the strobe. Strobe 0x400 -> peak stays 0x400, hold reloads. Strobe 0x700 -> peak 0x100, L=1 is not displayed while the hold is active (peak stays 0x400).
- Hold and decay, with HOLD_SAMPLES=2 and DECAY_STEP=0x100: strobe 0xC00, then 0x800 five times -> peak sequence 0x400, 0x400, 0x400, 0x300, 0x200, 0x100. Further samples -> 0x000 with no wrap.
- Clip: strobe ch1 = 0x000 -> CLIP=2'b10, ch1 magnitude 0x7FF, L=10, HEXR=1110111. Assert CLIP_CLR in the same cycle as a stage-1 ch1 full-scale sample -> CLIP stays set. CLIP_CLR alone -> CLIP clears.
- Dot mode and selection: ch0 peak 0x400, ch1 peak 0x100, MODE=1. CH_SEL=0 -> LED=0x010. CH_SEL=1 -> LED=0x001 one cycle later. CH_SEL=5 -> shows ch0. With CLIP[0] set -> LED=0x210.
- Throughput: 8 consecutive strobes with rising ch0 values 0x900..0xF00 -> the peak tracks each one, and the final LED appears exactly 3 cycles after the last strobe.

Source files
------------

// File: rtl/level_meter_mc.sv
// Multi-channel peak-hold level meter with sticky clip flags; one selected channel
// drives a bar/dot LED meter and a hex digit of its bar level.
module level_meter_mc #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned LED_N        = 10,
    parameter int unsigned HOLD_SAMPLES = 4800,
    parameter int unsigned DECAY_STEP   = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       SAMPLE_TR,
    input  logic [CHANNELS*DATA_W-1:0] VALUE,
    input  logic [2:0]                 CH_SEL,
    input  logic                       MODE,
    input  logic                       CLIP_CLR,
    output logic [LED_N-1:0]           LED,
    output logic [6:0]                 HEXR,
    output logic [CHANNELS-1:0]        CLIP
);
    localparam int unsigned MAG_W  = DATA_W - 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam int unsigned PROD_W = MAG_W + 4;

    localparam logic [DATA_W-1:0] MID       = {1'b1, {MAG_W{1'b0}}};
    localparam logic [MAG_W-1:0]  MAG_FULL  = {MAG_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES);
    localparam logic [MAG_W-1:0]  DECAY     = MAG_W'(DECAY_STEP);
    localparam logic [PROD_W-1:0] SCALE     = PROD_W'(LED_N + 1);

    function automatic logic [MAG_W-1:0] rectify(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] diff;
        diff = MID - v;
        if (v[DATA_W-1]) begin
            return v[MAG_W-1:0];
        end else if (v == '0) begin
            return MAG_FULL;
        end
        return diff[MAG_W-1:0];
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] l);
        logic [6:0] g;
        unique case (l)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1100111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            4'hF: g = 7'b1110001;
        endcase
        return g;
    endfunction

    logic                      valid_q;
    logic [MAG_W-1:0]          mag_q  [CHANNELS];
    logic [MAG_W-1:0]          peak_q [CHANNELS];
    logic [HOLD_W-1:0]         hold_q [CHANNELS];
    logic [CHANNELS-1:0]       clip_q;
    logic [CHANNELS-1:0]       clip_set;
    logic [LED_N-1:0]          led_q;
    logic [LED_N-1:0]          led_d;
    logic [6:0]                hexr_q;
    logic [MAG_W-1:0]          peak_sel;
    logic                      clip_sel;
    logic [PROD_W-1:0]         prod;
    logic [3:0]                level;

    always_comb begin
        clip_set = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            clip_set[c] = valid_q && (mag_q[c] == MAG_FULL);
        end
    end

    // Stages 1 and 2: rectify on the strobe, then peak/hold/decay and clip on the next edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            clip_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                mag_q[c]  <= '0;
                peak_q[c] <= '0;
                hold_q[c] <= '0;
            end
        end else begin
            valid_q <= SAMPLE_TR;
            if (SAMPLE_TR) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    mag_q[c] <= rectify(VALUE[c*DATA_W +: DATA_W]);
                end
            end
            if (valid_q) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (mag_q[c] >= peak_q[c]) begin
                        peak_q[c] <= mag_q[c];
                        hold_q[c] <= HOLD_INIT;
                    end else if (hold_q[c] != '0) begin
                        hold_q[c] <= hold_q[c] - HOLD_W'(1);
                    end else if (32'(peak_q[c]) > DECAY_STEP) begin
                        peak_q[c] <= peak_q[c] - DECAY;
                    end else begin
                        peak_q[c] <= '0;
                    end
                end
            end
            // A set in the same cycle as a clear wins.
            clip_q <= (CLIP_CLR ? '0 : clip_q) | clip_set;
        end
    end

    // Out-of-range selections fall back to channel 0.
    always_comb begin
        peak_sel = peak_q[0];
        clip_sel = clip_q[0];
        for (int c = 1; c < CHANNELS; c++) begin
            if (int'(CH_SEL) == c) begin
                peak_sel = peak_q[c];
                clip_sel = clip_q[c];
            end
        end
        prod  = PROD_W'(peak_sel) * SCALE;
        level = prod[PROD_W-1 -: 4];
        led_d = '0;
        for (int i = 0; i < LED_N; i++) begin
            if (MODE) begin
                led_d[i] = (level != 4'd0) && (i == int'(level) - 1);
            end else begin
                led_d[i] = (i < int'(level));
            end
        end
        if (clip_sel) begin
            led_d[LED_N-1] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            led_q  <= '0;
            hexr_q <= 7'b0111111;
        end else begin
            led_q  <= led_d;
            hexr_q <= glyph(level);
        end
    end

    assign LED  = led_q;
    assign HEXR = hexr_q;
    assign CLIP = clip_q;

endmodule

// File: tb/tb_level_meter_mc.sv
// Self-checking bench for level_meter_mc: directed scenarios plus randomized traffic
// compared against a sample-level behavioural model of the meter.
module tb_level_meter_mc;
    localparam int CH   = 2;
    localparam int DW   = 12;
    localparam int LN   = 10;
    localparam int HOLD = 2;
    localparam int DEC  = 256;
    localparam int MID  = 1 << (DW - 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            str;
    logic [CH*DW-1:0] value;
    logic [2:0]      ch_sel;
    logic            mode;
    logic            clr;
    logic [LN-1:0]   led;
    logic [6:0]      hexr;
    logic [CH-1:0]   clip;

    int tests = 0;
    int fails = 0;

    // Model state: peak/hold/clip per channel plus the magnitude awaiting its peak update.
    int   m_peak [CH];
    int   m_hold [CH];
    bit   m_clip [CH];
    int   m_mag  [CH];
    bit   m_valid;
    int   exp_led;
    int   exp_hex;
    int   exp_clip;
    logic [6:0] glyph [16];

    level_meter_mc #(
        .CHANNELS(CH), .DATA_W(DW), .LED_N(LN), .HOLD_SAMPLES(HOLD), .DECAY_STEP(DEC)
    ) dut (
        .CLK(clk), .RESET(rst), .SAMPLE_TR(str), .VALUE(value), .CH_SEL(ch_sel),
        .MODE(mode), .CLIP_CLR(clr), .LED(led), .HEXR(hexr), .CLIP(clip)
    );

    always #5 clk = ~clk;

    function automatic int rect(int v);
        if (v >= MID) return v - MID;
        if (v == 0) return MID - 1;
        return MID - v;
    endfunction

    task automatic set_in(int v0, int v1);
        value[0 +: DW]  = DW'(v0);
        value[DW +: DW] = DW'(v1);
    endtask

    // One clock edge; the model consumes the inputs present at that edge.
    task automatic tick();
        bit r = rst;
        bit st = str;
        bit md = mode;
        bit cc = clr;
        int sel_in = int'(ch_sel);
        logic [CH*DW-1:0] val = value;
        int c;
        int lv;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < CH; k++) begin
                m_peak[k] = 0; m_hold[k] = 0; m_clip[k] = 0; m_mag[k] = 0;
            end
            m_valid = 0;
            exp_led = 0;
            exp_hex = 7'b0111111;
        end else begin
            c  = (sel_in < CH) ? sel_in : 0;
            lv = (m_peak[c] * (LN + 1)) / MID;
            if (md) exp_led = (lv > 0) ? (1 << (lv - 1)) : 0;
            else exp_led = (1 << lv) - 1;
            if (m_clip[c]) exp_led = exp_led | (1 << (LN - 1));
            exp_hex = int'(glyph[lv]);
            for (int k = 0; k < CH; k++) begin
                if (m_valid) begin
                    if (m_mag[k] >= m_peak[k]) begin
                        m_peak[k] = m_mag[k];
                        m_hold[k] = HOLD;
                    end else if (m_hold[k] > 0) begin
                        m_hold[k] = m_hold[k] - 1;
                    end else begin
                        m_peak[k] = (m_peak[k] > DEC) ? m_peak[k] - DEC : 0;
                    end
                end
                if (cc) m_clip[k] = 0;
                if (m_valid && m_mag[k] == MID - 1) m_clip[k] = 1;
            end
            m_valid = st;
            if (st) begin
                for (int k = 0; k < CH; k++) m_mag[k] = rect(int'(val[k*DW +: DW]));
            end
        end
        exp_clip = 0;
        for (int k = 0; k < CH; k++) if (m_clip[k]) exp_clip = exp_clip | (1 << k);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; str = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; str = 1'b1;
        set_in(12'hFFF, 12'hFFF);
        tick();
        tick();
        rst = 1'b0; str = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (led !== '0) begin
                fails++; $display("FAIL reset_led[%0d]: got %h want 000", i, led);
            end
            tests++;
            if (hexr !== 7'b0111111) begin
                fails++; $display("FAIL reset_hexr[%0d]: got %b want 0111111", i, hexr);
            end
            tests++;
            if (clip !== '0) begin
                fails++; $display("FAIL reset_clip[%0d]: got %b want 00", i, clip);
            end
        end
    endtask

    task automatic test_rectify();
        int vals [3] = '{12'hC00, 12'h400, 12'h700};
        ch_sel = 3'd0; mode = 1'b0;
        for (int s = 0; s < 3; s++) begin
            set_in(vals[s], 12'h800);
            str = 1'b1;
            tick();
            str = 1'b0;
            tick();
            tick();
            tests++;
            if (led !== 10'h01F) begin
                fails++; $display("FAIL rectify_led[%0d]: got %h want 01f", s, led);
            end
            tests++;
            if (hexr !== 7'b1101101) begin
                fails++; $display("FAIL rectify_hexr[%0d]: got %b want 1101101", s, hexr);
            end
            tests++;
            if (led !== LN'(exp_led)) begin
                fails++; $display("FAIL rectify_model[%0d]: got %h want %h", s, led, exp_led);
            end
        end
    endtask

    task automatic test_decay();
        int lvl [9] = '{5, 5, 5, 4, 2, 1, 0, 0, 0};
        int want;
        do_reset();
        ch_sel = 3'd0; mode = 1'b0;
        for (int t = 0; t < 11; t++) begin
            if (t < 9) begin
                set_in((t == 0) ? 12'hC00 : 12'h800, 12'h800);
                str = 1'b1;
            end else begin
                str = 1'b0;
            end
            tick();
            if (t >= 2) begin
                want = (1 << lvl[t-2]) - 1;
                tests++;
                if (led !== LN'(want)) begin
                    fails++; $display("FAIL decay_led[%0d]: got %h want %h", t - 2, led, want);
                end
                tests++;
                if (led !== LN'(exp_led)) begin
                    fails++; $display("FAIL decay_model[%0d]: got %h want %h", t - 2, led, exp_led);
                end
            end
        end
        str = 1'b0;
    endtask

    task automatic test_clip();
        do_reset();
        ch_sel = 3'd1; mode = 1'b0;
        set_in(12'h800, 12'h000);
        str = 1'b1;
        tick();
        str = 1'b0;
        tick();
        tests++;
        if (clip !== 2'b10) begin
            fails++; $display("FAIL clip_set: got %b want 10", clip);
        end
        tick();
        tests++;
        if (led !== 10'h3FF) begin
            fails++; $display("FAIL clip_led: got %h want 3ff", led);
        end
        tests++;
        if (hexr !== 7'b1110111) begin
            fails++; $display("FAIL clip_hexr: got %b want 1110111", hexr);
        end
        str = 1'b1;
        tick();
        str = 1'b0; clr = 1'b1;
        tick();
        tests++;
        if (clip !== 2'b10) begin
            fails++; $display("FAIL clip_set_wins: got %b want 10", clip);
        end
        tick();
        clr = 1'b0;
        tests++;
        if (clip !== 2'b00) begin
            fails++; $display("FAIL clip_clear: got %b want 00", clip);
        end
    endtask

    task automatic test_dot_sel();
        do_reset();
        mode = 1'b1; ch_sel = 3'd0;
        set_in(12'hC00, 12'h900);
        str = 1'b1;
        tick();
        str = 1'b0;
        tick();
        tick();
        tests++;
        if (led !== 10'h010) begin
            fails++; $display("FAIL dot_ch0: got %h want 010", led);
        end
        ch_sel = 3'd1;
        tick();
        tests++;
        if (led !== 10'h001) begin
            fails++; $display("FAIL dot_ch1: got %h want 001", led);
        end
        ch_sel = 3'd5;
        tick();
        tests++;
        if (led !== 10'h010) begin
            fails++; $display("FAIL dot_sel_oob: got %h want 010", led);
        end
        // Full-scale on ch0 sets its clip flag; then let the peak decay back to level 5.
        ch_sel = 3'd0;
        set_in(12'h000, 12'h900);
        str = 1'b1;
        tick();
        set_in(12'h800, 12'h900);
        for (int i = 0; i < 6; i++) tick();
        str = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (led !== 10'h210) begin
            fails++; $display("FAIL dot_clip: got %h want 210", led);
        end
        tests++;
        if (hexr !== 7'b1101101) begin
            fails++; $display("FAIL dot_clip_hexr: got %b want 1101101", hexr);
        end
        mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int vals [8] = '{12'h900, 12'h980, 12'hA00, 12'hB00, 12'hC00, 12'hD00, 12'hE00, 12'hF00};
        do_reset();
        ch_sel = 3'd0; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(vals[i], 12'h800);
            str = 1'b1;
            tick();
            tests++;
            if (led !== LN'(exp_led)) begin
                fails++; $display("FAIL b2b_model[%0d]: got %h want %h", i, led, exp_led);
            end
        end
        str = 1'b0;
        tick();
        tests++;
        if (led !== 10'h0FF) begin
            fails++; $display("FAIL b2b_penultimate: got %h want 0ff", led);
        end
        tick();
        tests++;
        if (led !== 10'h1FF) begin
            fails++; $display("FAIL b2b_final_led: got %h want 1ff", led);
        end
        tests++;
        if (hexr !== 7'b1100111) begin
            fails++; $display("FAIL b2b_final_hexr: got %b want 1100111", hexr);
        end
    endtask

    task automatic test_random();
        int r;
        int v [CH];
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            str    = ($urandom_range(0, 2) != 0);
            clr    = ($urandom_range(0, 15) == 0);
            mode   = 1'($urandom_range(0, 1));
            ch_sel = 3'($urandom_range(0, 7));
            for (int k = 0; k < CH; k++) begin
                r = int'($urandom_range(0, 9));
                v[k] = (r == 0) ? 0 : (r == 1) ? 4095 : int'($urandom_range(0, 4095));
            end
            set_in(v[0], v[1]);
            tick();
            tests++;
            if (led !== LN'(exp_led)) begin
                fails++; $display("FAIL rand_led[%0d]: got %h want %h", n, led, exp_led);
            end
            tests++;
            if (hexr !== 7'(exp_hex)) begin
                fails++; $display("FAIL rand_hexr[%0d]: got %b want %b", n, hexr, 7'(exp_hex));
            end
            tests++;
            if (clip !== CH'(exp_clip)) begin
                fails++; $display("FAIL rand_clip[%0d]: got %b want %b", n, clip, CH'(exp_clip));
            end
        end
        rst = 1'b0; str = 1'b0; clr = 1'b0;
    endtask

    initial begin
        glyph = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                  7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
                  7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        rst = 1'b1; str = 1'b0; clr = 1'b0; mode = 1'b0; ch_sel = 3'd0;
        value = '0;
        test_reset();
        test_rectify();
        test_decay();
        test_clip();
        test_dot_sel();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
